// File: rtl/fpu_denorm_frac_pipe_pkg.sv
// Shared constants and helpers for the fraction denorm predictor.
package fpu_denorm_pkg;
  localparam int GRP_W     = 3;
  localparam int FPU_TAG_W = 4;

  // Number of 3-bit groups needed to cover a dw-bit fraction.
  function automatic int ngrp(input int dw);
    return (dw + GRP_W - 1) / GRP_W;
  endfunction
endpackage

// File: rtl/fpu_denorm_frac_pipe_if.sv
// Producer/consumer handshake bundle for the denorm predictor.
interface fpu_denorm_frac_pipe_if #(parameter int DW = 52);
  import fpu_denorm_pkg::*;

  logic                 in_vld;
  logic                 in_rdy;
  logic [DW-1:0]        din1;
  logic [DW-1:0]        din2;
  logic [FPU_TAG_W-1:0] in_tag;
  logic                 out_vld;
  logic                 out_rdy;
  logic                 out_nz;
  logic                 out_denorm;
  logic [FPU_TAG_W-1:0] out_tag;

  modport slave (
    input  in_vld, din1, din2, in_tag, out_rdy,
    output in_rdy, out_vld, out_nz, out_denorm, out_tag
  );

  modport master (
    output in_vld, din1, din2, in_tag, out_rdy,
    input  in_rdy, out_vld, out_nz, out_denorm, out_tag
  );
endinterface

// File: rtl/fpu_denorm_frac_pipe_grp3.sv
// One 3-bit group: non-zero flag and "din2 msb >= din1 msb" within the group.
module fpu_denorm_grp3
  import fpu_denorm_pkg::*;
(
  input  logic [GRP_W-1:0] d1_i,
  input  logic [GRP_W-1:0] d2_i,
  output logic             nzg_o,
  output logic             dng_o
);
  logic [GRP_W-1:0] z;

  // z[i] marks bit positions where both operands are clear.
  assign z     = ~(d1_i | d2_i);
  assign nzg_o = ~&z;
  // d2 wins at bit i only if no operand has a set bit above i.
  assign dng_o = d2_i[2] | (z[2] & d2_i[1]) | (z[2] & z[1] & d2_i[0]);
endmodule

// File: rtl/fpu_denorm_frac_pipe.sv
// Two-stage denorm predictor: stage 1 captures per-group flags, stage 2
// performs the MSB-first priority reduce into the output registers.
module fpu_denorm_frac_pipe
  import fpu_denorm_pkg::*;
#(
  parameter int DW = 52
) (
  input  logic                 rclk,
  input  logic                 arst,
  fpu_denorm_frac_pipe_if.slave bus
);
  localparam int NGRP = ngrp(DW);
  localparam int XW   = NGRP * GRP_W;

  logic [XW-1:0]        d1x, d2x;
  logic [NGRP-1:0]      nzg, dng;
  logic [2:1]           vld_pipe_q, vld_pipe_d;
  logic                 s1_adv, s2_adv, in_rdy, in_xfer;
  logic [NGRP-1:0]      nzg_q, dng_q;
  logic [FPU_TAG_W-1:0] tag1_q;
  logic                 nz_q, nz_d, dn_q, dn_d;
  logic [FPU_TAG_W-1:0] tag_q;

  // Zero-extend at the MSB so the top group is padded with zeros.
  assign d1x = XW'(bus.din1);
  assign d2x = XW'(bus.din2);

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    fpu_denorm_grp3 u_grp (
      .d1_i  (d1x[g*GRP_W +: GRP_W]),
      .d2_i  (d2x[g*GRP_W +: GRP_W]),
      .nzg_o (nzg[g]),
      .dng_o (dng[g])
    );
  end

  assign s2_adv  = ~vld_pipe_q[2] | bus.out_rdy;
  assign s1_adv  = vld_pipe_q[1] & s2_adv;
  assign in_rdy  = ~vld_pipe_q[1] | s2_adv;
  assign in_xfer = bus.in_vld & in_rdy;

  // Valid bits: stage 1 fills on transfer / drains on advance; stage 2 follows.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (in_xfer)     vld_pipe_d[1] = 1'b1;
    else if (s1_adv) vld_pipe_d[1] = 1'b0;
    if (s2_adv)      vld_pipe_d[2] = vld_pipe_q[1] | (vld_pipe_q[2] & ~bus.out_rdy);
  end

  // Valid state register; reset drops every in-flight entry.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) vld_pipe_q <= '0;
    else      vld_pipe_q <= vld_pipe_d;
  end

  // Stage 1 data: load only on transfer so idle-bus garbage never enters.
  always_ff @(posedge rclk) begin
    if (in_xfer) begin
      nzg_q  <= nzg;
      dng_q  <= dng;
      tag1_q <= bus.in_tag;
    end
  end

  // Priority reduce: the highest non-zero group decides the denorm flag.
  always_comb begin
    nz_d = |nzg_q;
    dn_d = 1'b0;
    for (int g = 0; g < NGRP; g++)
      if (nzg_q[g]) dn_d = dng_q[g];
  end

  // Output registers load only when stage 1 moves forward; held during stall.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      nz_q  <= 1'b0;
      dn_q  <= 1'b0;
      tag_q <= '0;
    end else if (s1_adv) begin
      nz_q  <= nz_d;
      dn_q  <= dn_d;
      tag_q <= tag1_q;
    end
  end

  assign bus.in_rdy     = in_rdy;
  assign bus.out_vld    = vld_pipe_q[2];
  assign bus.out_nz     = nz_q;
  assign bus.out_denorm = dn_q;
  assign bus.out_tag    = tag_q;
endmodule

// File: tb/tb_fpu_denorm_frac_pipe.sv
// Scoreboard bench: the driver queues hand-computed results on each input
// transfer, the monitor pops and compares on each output transfer.
module tb_fpu_denorm_frac_pipe;
  localparam int DW = 52;

  typedef struct packed {
    logic       nz;
    logic       dn;
    logic [3:0] tag;
  } exp_t;

  logic rclk, arst;
  fpu_denorm_frac_pipe_if #(.DW(DW)) bus ();

  fpu_denorm_frac_pipe #(.DW(DW)) dut (
    .rclk (rclk),
    .arst (arst),
    .bus  (bus)
  );

  exp_t          q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            n_acc  = 0;
  logic [DW-1:0] va [10];
  logic [DW-1:0] vb [10];
  logic          ez [10];
  logic          ed [10];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present a vector until accepted; expectation queued just before the edge.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [3:0] t, input logic enz, input logic edn);
    exp_t e;
    e.nz = enz; e.dn = edn; e.tag = t;
    bus.in_vld = 1'b1; bus.din1 = a; bus.din2 = b; bus.in_tag = t;
    for (int i = 0; i < 60; i++) begin
      @(negedge rclk);
      if (bus.in_rdy) begin
        q.push_back(e);
        n_acc++;
        @(posedge rclk); #1;
        return;
      end
      @(posedge rclk); #1;
    end
    chk("send_timeout", 0, 1);
    bus.in_vld = 1'b0;
  endtask

  // Drop valid and scramble the data lines so stray capture would show up.
  task automatic idle();
    bus.in_vld = 1'b0;
    bus.din1   = {$urandom, $urandom};
    bus.din2   = {$urandom, $urandom};
    bus.in_tag = 4'($urandom);
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge rclk) begin
    if (!arst && bus.out_vld && bus.out_rdy) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_tag", int'(bus.out_tag), 16);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_nz",  int'(bus.out_nz),     int'(e.nz));
        chk("sb_dn",  int'(bus.out_denorm), int'(e.dn));
        chk("sb_tag", int'(bus.out_tag),    int'(e.tag));
      end
    end
  end

  initial begin
    logic [DW-1:0] ones, b51, b50;
    logic [6:0]    snap;
    int            base, run, cnt;
    bit            seen;
    ones = '1;
    b51  = '0; b51[51] = 1'b1;
    b50  = '0; b50[50] = 1'b1;
    va[0] = 'h8;  vb[0] = 'h8;  ez[0] = 1; ed[0] = 1;
    va[1] = 'h10; vb[1] = 'hF;  ez[1] = 1; ed[1] = 0;
    va[2] = 'h0;  vb[2] = 'h0;  ez[2] = 0; ed[2] = 0;
    va[3] = ones; vb[3] = b51;  ez[3] = 1; ed[3] = 1;
    va[4] = b51;  vb[4] = b50;  ez[4] = 1; ed[4] = 0;
    va[5] = 'h5;  vb[5] = 'h0;  ez[5] = 1; ed[5] = 0;
    va[6] = 'h0;  vb[6] = 'h1;  ez[6] = 1; ed[6] = 1;
    va[7] = 'h3;  vb[7] = 'h2;  ez[7] = 1; ed[7] = 1;
    va[8] = 'h4;  vb[8] = 'h3;  ez[8] = 1; ed[8] = 0;
    va[9] = 'h7;  vb[9] = 'h8;  ez[9] = 1; ed[9] = 1;

    arst = 1'b1;
    bus.out_rdy = 1'b1;
    idle();
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_out_vld", int'(bus.out_vld),    0);
    chk("rst_in_rdy",  int'(bus.in_rdy),     1);
    chk("rst_out_nz",  int'(bus.out_nz),     0);
    chk("rst_out_dn",  int'(bus.out_denorm), 0);
    chk("rst_out_tag", int'(bus.out_tag),    0);
    arst = 1'b0;
    @(posedge rclk); #1;

    // Single vector: output appears exactly two edges after the transfer.
    send(va[0], vb[0], 4'h1, ez[0], ed[0]);
    idle();
    @(negedge rclk);
    chk("lat_early", int'(bus.out_vld), 0);
    @(negedge rclk);
    chk("lat_2cyc",  int'(bus.out_vld), 1);
    chk("lat_tag",   int'(bus.out_tag), 1);
    repeat (4) @(posedge rclk);
    #1;

    // Back-to-back burst of 8 with the consumer always ready.
    fork
      begin
        for (int i = 0; i < 8; i++) send(va[i], vb[i], 4'(i + 2), ez[i], ed[i]);
        idle();
      end
      begin
        run = 0; seen = 0;
        for (int c = 0; c < 40; c++) begin
          @(negedge rclk);
          if (bus.out_vld) begin run++; seen = 1; end
          else if (seen) break;
        end
        chk("burst_consecutive", run, 8);
      end
    join
    @(posedge rclk); #1;

    // Back-pressure: 4 offered while the consumer stalls for 5 cycles.
    bus.out_rdy = 1'b0;
    base = n_acc;
    fork
      begin
        send(va[8], vb[8], 4'hA, ez[8], ed[8]);
        send(va[9], vb[9], 4'hB, ez[9], ed[9]);
        send(va[0], vb[0], 4'hC, ez[0], ed[0]);
        send(va[1], vb[1], 4'hD, ez[1], ed[1]);
        idle();
      end
      begin
        repeat (3) @(negedge rclk);
        snap = {bus.out_vld, bus.out_nz, bus.out_denorm, bus.out_tag};
        repeat (2) @(negedge rclk);
        chk("stall_stable", int'({bus.out_vld, bus.out_nz, bus.out_denorm, bus.out_tag}), int'(snap));
        chk("stall_in_rdy", int'(bus.in_rdy),  0);
        chk("stall_acc",    n_acc - base,      2);
        chk("stall_vld",    int'(bus.out_vld), 1);
        chk("stall_tag",    int'(bus.out_tag), 'hA);
        @(posedge rclk); #1;
        bus.out_rdy = 1'b1;
      end
    join
    repeat (10) @(posedge rclk);
    #1;
    chk("stall_drained", q.size(), 0);

    // Reset with two entries in flight: both must vanish.
    bus.out_rdy = 1'b0;
    send(va[2], vb[2], 4'hE, ez[2], ed[2]);
    send(va[3], vb[3], 4'hF, ez[3], ed[3]);
    idle();
    #1;
    chk("inflight_vld", int'(bus.out_vld), 1);
    arst = 1'b1;
    q.delete();
    #1;
    chk("arst_out_vld", int'(bus.out_vld), 0);
    chk("arst_in_rdy",  int'(bus.in_rdy),  1);
    chk("arst_out_tag", int'(bus.out_tag), 0);
    @(posedge rclk); #1;
    arst = 1'b0;
    bus.out_rdy = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge rclk);
      if (bus.out_vld) cnt++;
    end
    chk("no_stale_out", cnt, 0);
    @(posedge rclk); #1;
    send(va[4], vb[4], 4'h3, ez[4], ed[4]);
    send(va[9], vb[9], 4'h4, ez[9], ed[9]);
    idle();
    for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge rclk);
    #1;
    chk("final_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
